// File: rtl/pc_next_unit.sv
// Registered program counter with next-PC selection (sequential, branch, jump, call, return).
// Define PC_RAS_EN to build in the hardware return-address stack; otherwise call acts as jump.
module pc_next_unit #(
    parameter int                WIDTH     = 32,
    parameter int                IMM_WIDTH = 16,
    parameter logic [WIDTH-1:0]  RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic                 jump,
    input  logic                 call,
    input  logic                 ret,
    input  logic [WIDTH-1:0]     jump_target,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_plus1,
    output logic [WIDTH-1:0]     branch_target,
    output logic                 ras_empty,
    output logic                 ras_full,
    output logic                 ras_err
);

    localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_plus1;
    logic [WIDTH-1:0] w_imm_sext;
    logic [WIDTH-1:0] w_branch_target;
    logic             w_ret_sel;
    logic             w_ret_hit;
    logic [WIDTH-1:0] w_ret_data;

    assign w_pc_plus1      = r_pc + PC_ONE;
    assign w_imm_sext      = {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    assign w_branch_target = w_pc_plus1 + w_imm_sext;

`ifdef PC_RAS_EN
    localparam int               PTR_W   = $clog2(RAS_DEPTH);
    localparam int               CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic             r_ras_err;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_err;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_MAX);
    assign w_ret_sel  = ret;
    assign w_ret_hit  = ret && !w_empty;
    assign w_ret_data = r_ras[r_top];
    // A return masks a simultaneous call, so only a lone call may push.
    assign w_pop      = !stall && ret && !w_empty;
    assign w_push     = !stall && !ret && call;
    assign w_err      = !stall && ((ret && w_empty) || (!ret && call && w_full));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top     <= '0;
            r_count   <= '0;
            r_ras_err <= 1'b0;
        end else begin
            r_ras_err <= w_err;
            if (w_push) begin
                r_top <= r_top + PTR_ONE;
                if (!w_full) begin
                    r_count <= r_count + CNT_ONE;
                end
            end else if (w_pop) begin
                r_top   <= r_top - PTR_ONE;
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Contents survive reset; a full stack wraps onto its oldest entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_top + PTR_ONE] <= w_pc_plus1;
        end
    end

    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_err   = r_ras_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ret & (RAS_DEPTH > 1);
    assign w_ret_sel    = 1'b0;
    assign w_ret_hit    = 1'b0;
    assign w_ret_data   = '0;
    assign ras_empty    = 1'b1;
    assign ras_full     = 1'b0;
    assign ras_err      = 1'b0;
`endif

    always_comb begin
        w_pc_next = w_pc_plus1;
        if (stall) begin
            w_pc_next = r_pc;
        end else if (w_ret_sel) begin
            w_pc_next = w_ret_hit ? w_ret_data : w_pc_plus1;
        end else if (call || jump) begin
            w_pc_next = jump_target;
        end else if (branch_taken) begin
            w_pc_next = w_branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc            = r_pc;
    assign pc_plus1      = w_pc_plus1;
    assign branch_target = w_branch_target;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model; honours PC_RAS_EN like the design.
module tb_pc_next_unit;

`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] imm = '0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [31:0] branch_target;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int checks = 0;
    int errors = 0;

    // Reference state: the PC, the stack as a queue (back = newest) and the error pulse.
    logic [31:0] mpc;
    logic [31:0] mq[$];
    logic        merr;

    pc_next_unit #(
        .WIDTH(32), .IMM_WIDTH(16), .RESET_PC(32'h0), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .imm(imm), .jump(jump), .call(call), .ret(ret), .jump_target(jump_target),
        .pc(pc), .pc_plus1(pc_plus1), .branch_target(branch_target),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mpc  = 32'h0;
        mq.delete();
        merr = 1'b0;
    endtask

    task automatic model_update();
        logic [31:0] ret_addr;
        merr = 1'b0;
        if (!stall) begin
            if (RAS_EN && ret) begin
                if (mq.size() > 0) begin
                    mpc = mq.pop_back();
                end else begin
                    mpc  = mpc + 32'd1;
                    merr = 1'b1;
                end
            end else if (call) begin
                if (RAS_EN) begin
                    ret_addr = mpc + 32'd1;
                    mq.push_back(ret_addr);
                    if (mq.size() > DEPTH) begin
                        void'(mq.pop_front());
                        merr = 1'b1;
                    end
                end
                mpc = jump_target;
            end else if (jump) begin
                mpc = jump_target;
            end else if (branch_taken) begin
                mpc = mpc + 32'd1 + 32'($signed(imm));
            end else begin
                mpc = mpc + 32'd1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; imm = '0; jump_target = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #12;
        checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h want %h", pc, 32'h0); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b want 1", ras_empty); end
        checks++; if (ras_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", ras_full); end
        checks++; if (ras_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", ras_err); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc !== 32'(i)) begin errors++; $display("[TB] FAIL seq_pc%0d got %h want %h", i, pc, 32'(i)); end
        end
    endtask

    task automatic test_branch();
        jump = 1; jump_target = 32'h10;
        tick();
        jump = 0;
        checks++; if (pc !== 32'h10) begin errors++; $display("[TB] FAIL br_setup got %h want 10", pc); end
        imm = 16'hFFFC; branch_taken = 1;
        #1;
        checks++; if (branch_target !== 32'h0D) begin errors++; $display("[TB] FAIL br_target got %h want 0d", branch_target); end
        checks++; if (pc_plus1 !== 32'h11) begin errors++; $display("[TB] FAIL br_plus1 got %h want 11", pc_plus1); end
        tick();
        branch_taken = 0;
        checks++; if (pc !== 32'h0D) begin errors++; $display("[TB] FAIL br_taken got %h want 0d", pc); end
        jump = 1; jump_target = 32'hFFFF_FFFF;
        tick();
        jump = 0;
        #1;
        checks++; if (pc_plus1 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_plus1 got %h want 0", pc_plus1); end
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc got %h want 0", pc); end
        jump = 1; jump_target = 32'hFFFF_FFF0;
        tick();
        jump = 0; imm = 16'h0020;
        #1;
        checks++; if (branch_target !== 32'h11) begin errors++; $display("[TB] FAIL br_fwd_wrap got %h want 11", branch_target); end
        jump = 1; jump_target = 32'h2;
        tick();
        jump = 0; imm = 16'h8000;
        #1;
        checks++; if (branch_target !== 32'hFFFF_8003) begin errors++; $display("[TB] FAIL br_back_wrap got %h want ffff8003", branch_target); end
        imm = '0;
    endtask

    task automatic test_call_ret();
        logic [31:0] exp_ret;
`ifdef PC_RAS_EN
        exp_ret = 32'h6;
`else
        exp_ret = 32'h43;
`endif
        do_reset();
        jump = 1; jump_target = 32'h5;
        tick();
        jump = 0; call = 1; jump_target = 32'h40;
        tick();
        call = 0;
        checks++; if (pc !== 32'h40) begin errors++; $display("[TB] FAIL call_pc got %h want 40", pc); end
        tick();
        checks++; if (pc !== 32'h41) begin errors++; $display("[TB] FAIL call_pc1 got %h want 41", pc); end
        tick();
        checks++; if (pc !== 32'h42) begin errors++; $display("[TB] FAIL call_pc2 got %h want 42", pc); end
        ret = 1;
        tick();
        ret = 0;
        checks++; if (pc !== exp_ret) begin errors++; $display("[TB] FAIL ret_pc got %h want %h", pc, exp_ret); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL ret_empty got %b want 1", ras_empty); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc[5];
        logic        exp_err[5];
`ifdef PC_RAS_EN
        exp_pc  = '{32'h6, 32'h5, 32'h4, 32'h3, 32'h4};
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_pc  = '{32'h7, 32'h8, 32'h9, 32'hA, 32'hB};
        exp_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        tick();
        for (int i = 1; i <= 5; i++) begin
            call = 1; jump_target = 32'(i + 1);
            tick();
            checks++; if (pc !== 32'(i + 1)) begin errors++; $display("[TB] FAIL ovf_pc%0d got %h want %h", i, pc, 32'(i + 1)); end
            checks++; if (ras_err !== merr) begin errors++; $display("[TB] FAIL ovf_err%0d got %b want %b", i, ras_err, merr); end
        end
        call = 0;
        checks++; if (ras_full !== RAS_EN) begin errors++; $display("[TB] FAIL ovf_full got %b want %b", ras_full, RAS_EN); end
        ret = 1;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++; if (pc !== exp_pc[j]) begin errors++; $display("[TB] FAIL ret_seq%0d got %h want %h", j, pc, exp_pc[j]); end
            checks++; if (ras_err !== exp_err[j]) begin errors++; $display("[TB] FAIL ret_err%0d got %b want %b", j, ras_err, exp_err[j]); end
        end
        ret = 0;
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL unf_empty got %b want 1", ras_empty); end
        tick();
        checks++; if (ras_err !== 1'b0) begin errors++; $display("[TB] FAIL err_pulse_len got %b want 0", ras_err); end
    endtask

    task automatic test_priority_stall();
        logic [31:0] exp_pc;
        exp_pc = RAS_EN ? 32'h20 : 32'h99;
        do_reset();
        jump = 1; jump_target = 32'h1F;
        tick();
        jump = 0; call = 1; jump_target = 32'h80;
        tick();
        ret = 1; call = 1; jump = 1; jump_target = 32'h99;
        tick();
        checks++; if (pc !== exp_pc) begin errors++; $display("[TB] FAIL prio_pc got %h want %h", pc, exp_pc); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL prio_nopush got %b want 1", ras_empty); end
        stall = 1; ret = 1; call = 0; jump = 1; jump_target = 32'h300;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (pc !== exp_pc) begin errors++; $display("[TB] FAIL stall_pc%0d got %h want %h", k, pc, exp_pc); end
            checks++; if (ras_err !== 1'b0) begin errors++; $display("[TB] FAIL stall_err%0d got %b want 0", k, ras_err); end
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        call = 1; jump_target = 32'h100;
        tick();
        jump_target = 32'h200;
        tick();
        call = 0;
        checks++; if (ras_empty !== !RAS_EN) begin errors++; $display("[TB] FAIL pre_rst_empty got %b want %b", ras_empty, !RAS_EN); end
        checks++; if (ras_err !== 1'b0) begin errors++; $display("[TB] FAIL call_err got %b want 0", ras_err); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL async_pc got %h want 0", pc); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL async_empty got %b want 1", ras_empty); end
        checks++; if (ras_full !== 1'b0) begin errors++; $display("[TB] FAIL async_full got %b want 0", ras_full); end
        #2;
        rst_n = 1'b1;
        tick();
        checks++; if (pc !== 32'h1) begin errors++; $display("[TB] FAIL post_rst_pc got %h want 1", pc); end
    endtask

    task automatic test_random();
        logic [31:0] exp_bt;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            stall        = ($urandom_range(0, 7) == 0);
            ret          = ($urandom_range(0, 4) == 0);
            call         = ($urandom_range(0, 3) == 0);
            jump         = ($urandom_range(0, 5) == 0);
            branch_taken = ($urandom_range(0, 2) == 0);
            imm          = 16'($urandom);
            jump_target  = $urandom;
            tick();
            #1;
            exp_bt = mpc + 32'd1 + 32'($signed(imm));
            checks++; if (pc !== mpc) begin errors++; $display("[TB] FAIL rnd_pc@%0d got %h want %h", n, pc, mpc); end
            checks++; if (pc_plus1 !== mpc + 32'd1) begin errors++; $display("[TB] FAIL rnd_plus1@%0d got %h want %h", n, pc_plus1, mpc + 32'd1); end
            checks++; if (branch_target !== exp_bt) begin errors++; $display("[TB] FAIL rnd_bt@%0d got %h want %h", n, branch_target, exp_bt); end
            checks++; if (ras_empty !== (mq.size() == 0)) begin errors++; $display("[TB] FAIL rnd_empty@%0d got %b want %b", n, ras_empty, mq.size() == 0); end
            checks++; if (ras_full !== (mq.size() == DEPTH)) begin errors++; $display("[TB] FAIL rnd_full@%0d got %b want %b", n, ras_full, mq.size() == DEPTH); end
            checks++; if (ras_err !== merr) begin errors++; $display("[TB] FAIL rnd_err@%0d got %b want %b", n, ras_err, merr); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow();
        test_priority_stall();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
